// File: rtl/buffer_arbiter_if.sv
// Handshake bundle between the buffer arbiter and its three agents
// (snooper, CPU, forwarder).
//   sn_done   : snooper finished filling its buffer
//   cpu_acc   : CPU accepts its current packet
//   cpu_rej   : CPU rejects its current packet
//   fwd_done  : forwarder finished its buffer
//   sn_sel, cpu_sel, fwd_sel : buffer owned by each agent
//                              (00 none, 01 ping, 10 pang, 11 pung)
//   ready_cnt : buffers filled and waiting for the CPU
//   accq_cnt  : buffers accepted and waiting for the forwarder
// Modports: slave = arbiter side, master = agent/driver side.
interface buffer_arbiter_if;
  logic       sn_done;
  logic       cpu_acc;
  logic       cpu_rej;
  logic       fwd_done;
  logic [1:0] sn_sel;
  logic [1:0] cpu_sel;
  logic [1:0] fwd_sel;
  logic [1:0] ready_cnt;
  logic [1:0] accq_cnt;

  modport slave (
    input  sn_done, cpu_acc, cpu_rej, fwd_done,
    output sn_sel, cpu_sel, fwd_sel, ready_cnt, accq_cnt
  );

  modport master (
    output sn_done, cpu_acc, cpu_rej, fwd_done,
    input  sn_sel, cpu_sel, fwd_sel, ready_cnt, accq_cnt
  );
endinterface

// File: rtl/buffer_arbiter.sv
// Three-buffer (ping/pang/pung) ownership arbiter for a packet memory.
// Buffers circulate FREE -> SN -> READY -> CPU -> ACC -> FWD -> FREE, with a
// CPU reject short-cutting CPU -> FREE. Two depth-3 FIFOs (ready queue and
// accept queue) keep buffers in strict fill order.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : buffer_arbiter_if.slave (agent handshakes, sel outputs, counts)
// Build option: define PKTMEM_FWD_EN to compile in the forwarder path.
// Without it cpu_acc frees the buffer like cpu_rej, the accept queue is
// removed, fwd_sel/accq_cnt are tied to 0 and fwd_done is ignored.
module buffer_arbiter (
  input logic              clk,
  input logic              rst,
  buffer_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {FREE, SN, READY, CPU, ACC, FWD} buf_st_t;

  typedef struct packed {
    logic [1:0] e0;
    logic [1:0] e1;
    logic [1:0] e2;
    logic [1:0] cnt;
  } q_t;

  // Pop shifts the head out first, then a push lands behind the survivors,
  // so a simultaneous push+pop leaves the count unchanged.
  function automatic q_t q_step(input q_t q, input logic push,
                                input logic [1:0] id, input logic pop);
    q_t r;
    r = q;
    if (pop) begin
      r.e0  = q.e1;
      r.e1  = q.e2;
      r.e2  = 2'd0;
      r.cnt = q.cnt - 2'd1;
    end
    if (push) begin
      case (r.cnt)
        2'd0:    r.e0 = id;
        2'd1:    r.e1 = id;
        default: r.e2 = id;
      endcase
      r.cnt = r.cnt + 2'd1;
    end
    return r;
  endfunction

  function automatic logic [1:0] lowest_free(input buf_st_t s1,
                                             input buf_st_t s2,
                                             input buf_st_t s3);
    if (s1 == FREE)      return 2'd1;
    else if (s2 == FREE) return 2'd2;
    else if (s3 == FREE) return 2'd3;
    else                 return 2'd0;
  endfunction

  buf_st_t    st [1:3];
  logic [1:0] sn_sel_r;
  logic [1:0] cpu_sel_r;
  q_t         rdy_q;
  q_t         rdy_nxt;
  logic [1:0] free_id;
  logic       sn_claim;
  logic       sn_rel;
  logic       cpu_claim;
  logic       cpu_free_ev;

  // Claims look only at registered state, so a buffer released at one edge
  // can be claimed at the next edge at the earliest, and an agent that
  // releases always shows sel = 00 for at least one cycle.
  always_comb begin
    free_id   = lowest_free(st[1], st[2], st[3]);
    sn_claim  = (sn_sel_r == 2'd0) && (free_id != 2'd0);
    sn_rel    = (sn_sel_r != 2'd0) && bus.sn_done;
    cpu_claim = (cpu_sel_r == 2'd0) && (rdy_q.cnt != 2'd0);
    rdy_nxt   = q_step(rdy_q, sn_rel, sn_sel_r, cpu_claim);
  end

`ifdef PKTMEM_FWD_EN
  logic [1:0] fwd_sel_r;
  q_t         acc_q;
  q_t         acc_nxt;
  logic       cpu_acc_ev;
  logic       fwd_claim;
  logic       fwd_rel;

  // Reject wins when acc and rej arrive together.
  always_comb begin
    cpu_free_ev = (cpu_sel_r != 2'd0) && bus.cpu_rej;
    cpu_acc_ev  = (cpu_sel_r != 2'd0) && bus.cpu_acc && !bus.cpu_rej;
    fwd_claim   = (fwd_sel_r == 2'd0) && (acc_q.cnt != 2'd0);
    fwd_rel     = (fwd_sel_r != 2'd0) && bus.fwd_done;
    acc_nxt     = q_step(acc_q, cpu_acc_ev, cpu_sel_r, fwd_claim);
  end
`else
  logic unused_fwd_done;

  always_comb begin
    cpu_free_ev = (cpu_sel_r != 2'd0) && (bus.cpu_rej || bus.cpu_acc);
  end
  assign unused_fwd_done = bus.fwd_done;
`endif

  // Each edge touches at most one buffer per agent, and the three agents
  // own/claim buffers in mutually exclusive states, so the per-buffer
  // writes below never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[1]     <= FREE;
      st[2]     <= FREE;
      st[3]     <= FREE;
      sn_sel_r  <= 2'd0;
      cpu_sel_r <= 2'd0;
      rdy_q     <= '0;
`ifdef PKTMEM_FWD_EN
      fwd_sel_r <= 2'd0;
      acc_q     <= '0;
`endif
    end else begin
      if (sn_rel) begin
        st[sn_sel_r] <= READY;
        sn_sel_r     <= 2'd0;
      end else if (sn_claim) begin
        st[free_id]  <= SN;
        sn_sel_r     <= free_id;
      end

      if (cpu_claim) begin
        st[rdy_q.e0] <= CPU;
        cpu_sel_r    <= rdy_q.e0;
      end else if (cpu_free_ev) begin
        st[cpu_sel_r] <= FREE;
        cpu_sel_r     <= 2'd0;
`ifdef PKTMEM_FWD_EN
      end else if (cpu_acc_ev) begin
        st[cpu_sel_r] <= ACC;
        cpu_sel_r     <= 2'd0;
`endif
      end

      rdy_q <= rdy_nxt;

`ifdef PKTMEM_FWD_EN
      if (fwd_claim) begin
        st[acc_q.e0] <= FWD;
        fwd_sel_r    <= acc_q.e0;
      end else if (fwd_rel) begin
        st[fwd_sel_r] <= FREE;
        fwd_sel_r     <= 2'd0;
      end
      acc_q <= acc_nxt;
`endif
    end
  end

  assign bus.sn_sel    = sn_sel_r;
  assign bus.cpu_sel   = cpu_sel_r;
  assign bus.ready_cnt = rdy_q.cnt;
`ifdef PKTMEM_FWD_EN
  assign bus.fwd_sel   = fwd_sel_r;
  assign bus.accq_cnt  = acc_q.cnt;
`else
  assign bus.fwd_sel   = 2'd0;
  assign bus.accq_cnt  = 2'd0;
`endif

endmodule

// File: tb/tb_buffer_arbiter.sv
// Testbench for buffer_arbiter: directed vector table plus hand-written
// sequences for the accept/forward path and asynchronous reset.
module tb_buffer_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffer_arbiter_if bus();

  buffer_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Input bits {sn_done, cpu_acc, cpu_rej, fwd_done}
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_SD   = 4'b1000;
  localparam logic [3:0] I_ACC  = 4'b0100;
  localparam logic [3:0] I_REJ  = 4'b0010;
  localparam logic [3:0] I_FD   = 4'b0001;

  // Expected outputs {sn_sel, cpu_sel, fwd_sel, ready_cnt, accq_cnt}
  typedef struct {
    logic [3:0] in;
    logic [9:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [19];

  function automatic logic [9:0] ex(input logic [1:0] sn, input logic [1:0] cpu,
                                    input logic [1:0] fwd, input logic [1:0] rc,
                                    input logic [1:0] ac);
    return {sn, cpu, fwd, rc, ac};
  endfunction

  function automatic vec_t mk(input logic [3:0] in, input logic [1:0] sn,
                              input logic [1:0] cpu, input logic [1:0] rc);
    vec_t v;
    v.in  = in;
    v.exp = ex(sn, cpu, 2'd0, rc, 2'd0);
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] want);
    logic [9:0] got;
    got = {bus.sn_sel, bus.cpu_sel, bus.fwd_sel, bus.ready_cnt, bus.accq_cnt};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got sn/cpu/fwd/rc/ac=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
               name, got[9:8], got[7:6], got[5:4], got[3:2], got[1:0],
               want[9:8], want[7:6], want[5:4], want[3:2], want[1:0]);
    end
  endtask

  task automatic step(input logic [3:0] in);
    {bus.sn_done, bus.cpu_acc, bus.cpu_rej, bus.fwd_done} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input string name);
    {bus.sn_done, bus.cpu_acc, bus.cpu_rej, bus.fwd_done} = I_NONE;
    rst = 1'b1;
    #1;
    check(name, ex(2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // All inputs pulsed with every sel 00: ignored, only the reset claim happens.
    vecs[0]  = mk(I_SD | I_ACC | I_REJ | I_FD, 2'd1, 2'd0, 2'd0);
    vecs[1]  = mk(I_NONE,        2'd1, 2'd0, 2'd0);
    vecs[2]  = mk(I_SD,          2'd0, 2'd0, 2'd1);
    vecs[3]  = mk(I_NONE,        2'd2, 2'd1, 2'd0);
    vecs[4]  = mk(I_SD,          2'd0, 2'd1, 2'd1);
    vecs[5]  = mk(I_NONE,        2'd3, 2'd1, 2'd1);
    vecs[6]  = mk(I_SD,          2'd0, 2'd1, 2'd2);
    vecs[7]  = mk(I_NONE,        2'd0, 2'd1, 2'd2);   // no buffer free: stall
    vecs[8]  = mk(I_REJ,         2'd0, 2'd0, 2'd2);
    vecs[9]  = mk(I_NONE,        2'd1, 2'd2, 2'd1);
    vecs[10] = mk(I_ACC | I_REJ, 2'd1, 2'd0, 2'd1);   // acc+rej counts as reject
    vecs[11] = mk(I_NONE,        2'd1, 2'd3, 2'd0);
    vecs[12] = mk(I_SD,          2'd0, 2'd3, 2'd1);
    vecs[13] = mk(I_NONE,        2'd2, 2'd3, 2'd1);   // pang reclaimed
    vecs[14] = mk(I_FD,          2'd2, 2'd3, 2'd1);   // fwd_done ignored
    vecs[15] = mk(I_SD | I_REJ,  2'd0, 2'd0, 2'd2);
    vecs[16] = mk(I_NONE,        2'd3, 2'd1, 2'd1);
    vecs[17] = mk(I_REJ,         2'd3, 2'd0, 2'd1);
    vecs[18] = mk(I_NONE,        2'd3, 2'd2, 2'd0);

    reset_dut("reset_hold");
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Accept / forward path
    reset_dut("reset_hold2");
    step(I_NONE); check("acc_claim_ping", ex(2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
    step(I_SD);   check("acc_fill_ping",  ex(2'd0, 2'd0, 2'd0, 2'd1, 2'd0));
    step(I_NONE); check("acc_cpu_ping",   ex(2'd2, 2'd1, 2'd0, 2'd0, 2'd0));
`ifdef PKTMEM_FWD_EN
    step(I_ACC);  check("acc_accept",     ex(2'd2, 2'd0, 2'd0, 2'd0, 2'd1));
    step(I_NONE); check("acc_fwd_claim",  ex(2'd2, 2'd0, 2'd1, 2'd0, 2'd0));
`else
    step(I_ACC);  check("acc_as_reject",  ex(2'd2, 2'd0, 2'd0, 2'd0, 2'd0));
    step(I_NONE); check("acc_no_fwd",     ex(2'd2, 2'd0, 2'd0, 2'd0, 2'd0));
`endif
    step(I_SD | I_FD); check("acc_fwd_done", ex(2'd0, 2'd0, 2'd0, 2'd1, 2'd0));
    step(I_NONE);      check("acc_ping_reuse", ex(2'd1, 2'd2, 2'd0, 2'd0, 2'd0));

`ifdef PKTMEM_FWD_EN
    // Bring all three buffers under ownership before the reset pulse.
    step(I_ACC);  check("own_acc_pang",  ex(2'd1, 2'd0, 2'd0, 2'd0, 2'd1));
    step(I_NONE); check("own_fwd_pang",  ex(2'd1, 2'd0, 2'd2, 2'd0, 2'd0));
    step(I_SD);   check("own_fill_ping", ex(2'd0, 2'd0, 2'd2, 2'd1, 2'd0));
    step(I_NONE); check("own_all_three", ex(2'd3, 2'd1, 2'd2, 2'd0, 2'd0));
`endif

    // Asynchronous reset mid-cycle abandons all ownership at once.
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", ex(2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    @(posedge clk);
    #1;
    check("rst_held", ex(2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
    rst = 1'b0;
    step(I_NONE); check("rst_reclaim", ex(2'd1, 2'd0, 2'd0, 2'd0, 2'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
